// File: rtl/adc_ads8864_opb_if.sv
// OPB slave front-end for the ADS8864 SAR ADC: drives CNVST/SCLK, shifts in
// 16-bit samples and buffers them in a word RAM readable over the bus.
`timescale 1ns/1ps
module adc_ads8864_opb_if #(
    parameter int unsigned CONV_CYCLES  = 32,
    parameter int unsigned QUIET_CYCLES = 4,
    parameter int unsigned RAM_DEPTH    = 256
) (
    input  logic        OPB_CLK,
    input  logic        OPB_RST,
    input  logic [31:0] OPB_ADDR,
    input  logic [31:0] OPB_DI,
    input  logic        OPB_WE,
    input  logic        OPB_RE,
    output logic [31:0] OPB_DO,
    output logic        AD_CNVST,
    output logic        AD_SCLK,
    input  logic        AD_SDOUT
);

    localparam int unsigned AW          = $clog2(RAM_DEPTH);
    localparam int unsigned CW          = 9;
    localparam int unsigned READ_CYCLES = 32;
    localparam int unsigned TMAX0       = (CONV_CYCLES > READ_CYCLES) ? CONV_CYCLES : READ_CYCLES;
    localparam int unsigned TMAX        = (TMAX0 > QUIET_CYCLES) ? TMAX0 : QUIET_CYCLES;
    localparam int unsigned TW          = $clog2(TMAX) + 1;

    typedef enum logic [2:0] {S_IDLE, S_CONV, S_READ, S_STORE, S_QUIET} state_e;

    state_e          state_q,  state_d;
    logic [TW-1:0]   timer_q,  timer_d;
    logic            cnvst_q,  cnvst_d;
    logic            sclk_q,   sclk_d;
    logic [15:0]     shift_q,  shift_d;
    logic [AW-1:0]   ptr_q,    ptr_d;
    logic [CW-1:0]   stored_q, stored_d;
    logic            done_q,   done_d;
    logic            cont_q,   cont_d;
    logic [CW-1:0]   count_q,  count_d;
    logic [31:0]     do_q,     do_d;
    logic [15:0]     mem_q [RAM_DEPTH];

    logic            sel_ram_c, sel_ctrl_c, sel_count_c, sel_status_c;
    logic            wr_ctrl_c, clear_c, start_c, ram_we_c, busy_c;
    logic [CW-1:0]   count_eff_c;
    logic [31:0]     status_c;
    logic [15:0]     rd_ram_c;
    logic [AW-1:0]   ram_idx_c;
    logic            unused_ok_c;

    assign unused_ok_c = ^{OPB_ADDR[31:12], OPB_ADDR[1:0], OPB_DI[31:9]};

    // Address decode and control strobes; CLEAR dominates START
    always_comb begin
        sel_ram_c    = (OPB_ADDR[11:10] == 2'b00);
        sel_ctrl_c   = (OPB_ADDR[11:0] == 12'h800);
        sel_count_c  = (OPB_ADDR[11:0] == 12'h804);
        sel_status_c = (OPB_ADDR[11:0] == 12'h808);
        wr_ctrl_c    = OPB_WE && sel_ctrl_c;
        clear_c      = wr_ctrl_c && OPB_DI[0];
        start_c      = wr_ctrl_c && OPB_DI[1] && !OPB_DI[0] && (state_q == S_IDLE);
        busy_c       = (state_q != S_IDLE);
        count_eff_c  = ((count_q == '0) || (count_q > CW'(RAM_DEPTH))) ? CW'(RAM_DEPTH) : count_q;
        status_c     = {15'd0, stored_q, 6'd0, done_q, busy_c};
        ram_idx_c    = OPB_ADDR[AW+1:2];
        rd_ram_c     = mem_q[ram_idx_c];
    end

    // Bus register writes and registered read mux
    always_comb begin
        cont_d  = cont_q;
        count_d = count_q;
        do_d    = '0;
        if (wr_ctrl_c) cont_d = OPB_DI[2];
        if (OPB_WE && sel_count_c) count_d = OPB_DI[CW-1:0];
        if (OPB_RE) begin
            if (sel_ram_c)         do_d = {16'd0, rd_ram_c};
            else if (sel_ctrl_c)   do_d = {29'd0, cont_q, 2'b00};
            else if (sel_count_c)  do_d = {23'd0, count_q};
            else if (sel_status_c) do_d = status_c;
        end
    end

    // Conversion sequencer
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q + TW'(1);
        cnvst_d  = cnvst_q;
        sclk_d   = 1'b0;
        shift_d  = shift_q;
        ptr_d    = ptr_q;
        stored_d = stored_q;
        done_d   = done_q;
        ram_we_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                timer_d = '0;
                cnvst_d = 1'b0;
                if (start_c) begin
                    state_d  = S_CONV;
                    cnvst_d  = 1'b1;
                    ptr_d    = '0;
                    stored_d = '0;
                    done_d   = 1'b0;
                end
            end
            S_CONV: begin
                if (timer_q == TW'(CONV_CYCLES - 1)) begin
                    state_d = S_READ;
                    timer_d = '0;
                    cnvst_d = 1'b0;
                end
            end
            S_READ: begin
                sclk_d = ~sclk_q;
                // Sample on the same edge that raises SCLK
                if (!sclk_q) shift_d = {shift_q[14:0], AD_SDOUT};
                if (timer_q == TW'(READ_CYCLES - 1)) begin
                    state_d = S_STORE;
                    timer_d = '0;
                    sclk_d  = 1'b0;
                end
            end
            S_STORE: begin
                ram_we_c = 1'b1;
                ptr_d    = ptr_q + AW'(1);
                if (stored_q != CW'(RAM_DEPTH)) stored_d = stored_q + CW'(1);
                state_d  = S_QUIET;
                timer_d  = '0;
            end
            S_QUIET: begin
                if (timer_q == TW'(QUIET_CYCLES - 1)) begin
                    timer_d = '0;
                    if (cont_q || (stored_q < count_eff_c)) begin
                        state_d = S_CONV;
                        cnvst_d = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (clear_c) begin
            state_d  = S_IDLE;
            timer_d  = '0;
            cnvst_d  = 1'b0;
            sclk_d   = 1'b0;
            ptr_d    = '0;
            stored_d = '0;
            done_d   = 1'b0;
            ram_we_c = 1'b0;
        end
    end

    always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
        if (OPB_RST) begin
            state_q  <= S_IDLE;
            timer_q  <= '0;
            cnvst_q  <= 1'b0;
            sclk_q   <= 1'b0;
            shift_q  <= '0;
            ptr_q    <= '0;
            stored_q <= '0;
            done_q   <= 1'b0;
            cont_q   <= 1'b0;
            count_q  <= CW'(1);
            do_q     <= '0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            cnvst_q  <= cnvst_d;
            sclk_q   <= sclk_d;
            shift_q  <= shift_d;
            ptr_q    <= ptr_d;
            stored_q <= stored_d;
            done_q   <= done_d;
            cont_q   <= cont_d;
            count_q  <= count_d;
            do_q     <= do_d;
        end
    end

    // Sample buffer holds its contents across reset
    always_ff @(posedge OPB_CLK) begin
        if (ram_we_c) mem_q[ptr_q] <= shift_q;
    end

    assign AD_CNVST = cnvst_q;
    assign AD_SCLK  = sclk_q;
    assign OPB_DO   = do_q;

endmodule

// File: tb/tb_adc_ads8864_opb_if.sv
// Directed bench for adc_ads8864_opb_if with a behavioural ADS8864 serial model.
`timescale 1ns/1ps
module tb_adc_ads8864_opb_if;

    logic        OPB_CLK = 1'b0;
    logic        OPB_RST = 1'b1;
    logic [31:0] OPB_ADDR = '0;
    logic [31:0] OPB_DI = '0;
    logic        OPB_WE = 1'b0;
    logic        OPB_RE = 1'b0;
    logic [31:0] OPB_DO;
    logic        AD_CNVST;
    logic        AD_SCLK;
    logic        AD_SDOUT = 1'b0;

    int n_cmp = 0;
    int n_mis = 0;
    int edge_cnt = 0;
    int wr_edge = 0;
    int cnv_hi_cnt = 0;
    int sclk_cnt = 0;
    int samp_n = 0;
    int samp_base = 0;
    logic        adc_inc = 1'b0;
    logic [15:0] adc_fixed = 16'h0000;
    logic [15:0] adc_word = 16'h0000;
    int  bitn = 0;
    logic cnv_prev = 1'b0;
    logic sclk_prev = 1'b0;

    adc_ads8864_opb_if dut (
        .OPB_CLK (OPB_CLK),
        .OPB_RST (OPB_RST),
        .OPB_ADDR(OPB_ADDR),
        .OPB_DI  (OPB_DI),
        .OPB_WE  (OPB_WE),
        .OPB_RE  (OPB_RE),
        .OPB_DO  (OPB_DO),
        .AD_CNVST(AD_CNVST),
        .AD_SCLK (AD_SCLK),
        .AD_SDOUT(AD_SDOUT)
    );

    always #20 OPB_CLK = ~OPB_CLK;

    always @(posedge OPB_CLK) edge_cnt++;
    always @(negedge OPB_CLK) if (AD_CNVST === 1'b1) cnv_hi_cnt++;
    always @(posedge AD_SCLK) sclk_cnt++;

    // ADC model: word latched at CNVST rise, MSB on CNVST fall, next bit on each SCLK fall
    always @(AD_CNVST, AD_SCLK) begin
        if (AD_CNVST && !cnv_prev) begin
            adc_word = adc_inc ? (16'h8000 + 16'(samp_n - samp_base)) : adc_fixed;
            samp_n++;
        end else if (!AD_CNVST && cnv_prev) begin
            bitn = 15;
            AD_SDOUT = adc_word[15];
        end else if (!AD_SCLK && sclk_prev && bitn > 0) begin
            bitn--;
            AD_SDOUT = adc_word[bitn];
        end
        cnv_prev  = AD_CNVST;
        sclk_prev = AD_SCLK;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        OPB_ADDR = a;
        OPB_DI   = d;
        OPB_WE   = 1'b1;
        @(negedge OPB_CLK);
        OPB_WE   = 1'b0;
        wr_edge  = edge_cnt;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        OPB_ADDR = a;
        OPB_RE   = 1'b1;
        @(negedge OPB_CLK);
        d = OPB_DO;
        OPB_RE = 1'b0;
    endtask

    task automatic wait_edge(input int n);
        while (edge_cnt < n) @(negedge OPB_CLK);
    endtask

    task automatic poll_idle(output logic [31:0] d);
        int t;
        t = 0;
        do begin
            bus_read(32'h808, d);
            t++;
        end while (d[0] !== 1'b0 && t < 2000);
    endtask

    initial begin
        logic [31:0] d;
        int e0, cnv_base, sclk_base, guard;

        repeat (3) @(negedge OPB_CLK);
        check("rst_cnvst", 32'(AD_CNVST), 32'd0);
        check("rst_sclk", 32'(AD_SCLK), 32'd0);
        check("rst_do", OPB_DO, 32'd0);
        OPB_RST = 1'b0;
        @(negedge OPB_CLK);
        bus_read(32'h808, d); check("rst_status", d, 32'h0);
        bus_read(32'h800, d); check("rst_ctrl", d, 32'h0);
        bus_read(32'h804, d); check("rst_count", d, 32'h1);
        @(negedge OPB_CLK);
        check("do_zero_no_re", OPB_DO, 32'h0);

        // Single conversion, fixed word
        adc_inc = 1'b0;
        adc_fixed = 16'hA5C3;
        cnv_base = cnv_hi_cnt;
        sclk_base = sclk_cnt;
        bus_write(32'h800, 32'h2);
        e0 = wr_edge;
        check("cnvst_rise", 32'(AD_CNVST), 32'd1);
        wait_edge(e0 + 4);
        bus_read(32'h808, d); check("status_200ns", d, 32'h1);
        wait_edge(e0 + 31);
        check("cnvst_last", 32'(AD_CNVST), 32'd1);
        wait_edge(e0 + 32);
        check("cnvst_fall", 32'(AD_CNVST), 32'd0);
        wait_edge(e0 + 33);
        check("sclk_first", 32'(AD_SCLK), 32'd1);
        wait_edge(e0 + 68);
        bus_read(32'h808, d); check("status_edge69", d, 32'h101);
        bus_read(32'h808, d); check("status_done", d, 32'h102);
        check("cnvst_clocks", 32'(cnv_hi_cnt - cnv_base), 32'd32);
        check("sclk_pulses", 32'(sclk_cnt - sclk_base), 32'd16);
        bus_read(32'h000, d); check("ram0_a5c3", d, 32'h0000_A5C3);

        // Four-sample run, incrementing words
        bus_write(32'h804, 32'h4);
        bus_read(32'h804, d); check("count_rb", d, 32'h4);
        samp_base = samp_n;
        adc_inc = 1'b1;
        bus_write(32'h800, 32'h2);
        poll_idle(d); check("run4_status", d, 32'h402);
        for (int i = 0; i < 4; i++) begin
            bus_read(32'(4 * i), d);
            check($sformatf("run4_ram%0d", i), d, 32'h8000 + 32'(i));
        end

        // Unmapped reads and read-only STATUS
        bus_read(32'h900, d); check("rd_900", d, 32'h0);
        bus_read(32'hFFC, d); check("rd_ffc", d, 32'h0);
        bus_write(32'h808, 32'hFFFF_FFFF);
        bus_read(32'h808, d); check("status_ro", d, 32'h402);
        bus_read(32'hFFFF_F808, d); check("addr_hi_ignored", d, 32'h402);

        // START together with CLEAR: CLEAR wins
        bus_write(32'h800, 32'h3);
        check("start_clear_cnvst", 32'(AD_CNVST), 32'd0);
        bus_read(32'h808, d); check("start_clear_status", d, 32'h0);

        // CLEAR aborts a run in progress
        bus_write(32'h800, 32'h2);
        e0 = wr_edge;
        wait_edge(e0 + 10);
        check("abort_pre_cnvst", 32'(AD_CNVST), 32'd1);
        bus_write(32'h800, 32'h1);
        check("abort_cnvst", 32'(AD_CNVST), 32'd0);
        bus_read(32'h808, d); check("abort_status", d, 32'h0);

        // Continuous mode wraps the buffer
        bus_write(32'h804, 32'h1);
        samp_base = samp_n;
        bus_write(32'h800, 32'h6);
        bus_read(32'h800, d); check("ctrl_rb_cont", d, 32'h4);
        guard = 0;
        while ((samp_n - samp_base) < 258 && guard < 30000) begin
            @(negedge OPB_CLK);
            guard++;
        end
        bus_read(32'h808, d); check("cont_saturated", d, 32'h0001_0001);
        bus_write(32'h800, 32'h0);
        poll_idle(d); check("cont_stop", d, 32'h0001_0002);
        bus_read(32'h000, d); check("wrap_ram0", d, 32'h8100);
        bus_read(32'h004, d); check("wrap_ram1", d, 32'h8101);
        bus_read(32'h008, d); check("wrap_ram2", d, 32'h8002);
        bus_read(32'h3FC, d); check("wrap_ram255", d, 32'h80FF);

        // Reset in the middle of the serial readout
        adc_inc = 1'b0;
        adc_fixed = 16'h1234;
        bus_write(32'h800, 32'h2);
        e0 = wr_edge;
        wait_edge(e0 + 41);
        check("pre_rst_sclk", 32'(AD_SCLK), 32'd1);
        #5 OPB_RST = 1'b1;
        #1;
        check("rst_async_sclk", 32'(AD_SCLK), 32'd0);
        check("rst_async_cnvst", 32'(AD_CNVST), 32'd0);
        @(negedge OPB_CLK);
        OPB_RST = 1'b0;
        bus_read(32'h808, d); check("rst_mid_status", d, 32'h0);
        bus_read(32'h804, d); check("rst_mid_count", d, 32'h1);
        bus_read(32'h000, d); check("rst_no_partial", d, 32'h8100);
        bus_write(32'h800, 32'h2);
        poll_idle(d); check("post_rst_status", d, 32'h102);
        bus_read(32'h000, d); check("post_rst_ram", d, 32'h1234);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/adc_ads8864_opb_if.md
ADC_ADS8864_OPB_IF -- requirements
Module: adc_ads8864_opb_if

Interface
REQ-001 Parameter CONV_CYCLES, default 32: clocks CNVST is held high per conversion (1.28 us at 25 MHz).
REQ-002 Parameter QUIET_CYCLES, default 4: clocks between the end of one readout and the next CNVST rise.
REQ-003 Parameter RAM_DEPTH, default 256: sample buffer depth, in 16-bit words.
REQ-004 Port OPB_CLK, in, 1: the block's only clock; all logic is on its rising edge.
REQ-005 Port OPB_RST, in, 1: reset, asynchronous, active-high.
REQ-006 Port OPB_ADDR, in, 32: bus address; bits [11:0] are decoded and the upper bits ignored.
REQ-007 Port OPB_DI, in, 32: write data.
REQ-008 Port OPB_WE, in, 1: write enable, sampled on every clock edge.
REQ-009 Port OPB_RE, in, 1: read enable.
REQ-010 Port OPB_DO, out, 32: registered read data.
REQ-011 Port AD_CNVST, out, 1: ADS8864 conversion start / output enable.
REQ-012 Port AD_SCLK, out, 1: ADS8864 serial clock, idle low.
REQ-013 Port AD_SDOUT, in, 1: ADS8864 serial data, MSB first; the ADC changes it on CNVST fall and on SCLK falling edges.

Function
REQ-014 Register map:
- 0x000-0x3FC: sample RAM, read-only; word index = ADDR[9:2]; data zero-extended to 32 bits.
- 0x800: CTRL, read/write.
- 0x804: COUNT, read/write.
- 0x808: STATUS, read-only.
- Any other address reads 0; writes to it are ignored.
REQ-015 CTRL bits:
- bit0 CLEAR: self-clearing; zeroes the write pointer and DONE; if busy, also aborts to IDLE.
- bit1 START: self-clearing; ignored while busy.
- bit2 CONT: stored; enables continuous wrap mode.
- Readback returns bit2 and zeros elsewhere.
REQ-016 COUNT[8:0] is the number of samples per run; 0 and values above RAM_DEPTH mean RAM_DEPTH; reset value 1.
REQ-017 STATUS bits:
- bit0 BUSY.
- bit1 DONE: sticky; cleared by START or CLEAR.
- bits[16:8]: samples stored in the current/last run.
- Other bits 0.
REQ-018 OPB_DO updates on the first clock edge with OPB_RE=1 (one-cycle latency); it is 0 on edges with OPB_RE=0.
REQ-019 A write occurs on every edge with OPB_WE=1; repeated identical writes are harmless.
REQ-020 FSM states: IDLE, CONV, READ, STORE, QUIET.
REQ-021 IDLE: CNVST=0, SCLK=0. START goes to CONV, sets BUSY, clears DONE and the pointer.
REQ-022 CONV: CNVST=1 for exactly CONV_CYCLES clocks, then go to READ with CNVST=0.
REQ-023 READ: 32 clocks; AD_SCLK toggles every clock starting low (12.5 MHz, 16 rising edges); AD_SDOUT is shifted in MSB-first on each clock where SCLK goes 0->1.
REQ-024 STORE: one clock; writes the 16-bit word to RAM[pointer], increments the pointer and stored count.
REQ-025 QUIET: QUIET_CYCLES clocks, then:
- CONV if stored < COUNT, or if CONT=1 (pointer wraps at RAM_DEPTH and the count saturates);
- otherwise IDLE with BUSY=0, DONE=1.
REQ-026 A full sample therefore takes CONV_CYCLES+32+1+QUIET_CYCLES clocks (69 by default).
REQ-027 In CONT mode, clearing CONT ends the run at the next QUIET; CLEAR aborts immediately.
REQ-028 A simultaneous START and CLEAR: CLEAR wins and START is ignored.
REQ-029 A RAM read of the word being written in the same clock returns the old content.

Reset
REQ-030 While OPB_RST=1, asynchronously: state=IDLE, AD_CNVST=0, AD_SCLK=0, OPB_DO=0, CTRL=0, COUNT=1, STATUS=0, pointer=0, shift register=0.
REQ-031 RAM contents are not reset; a reset mid-run aborts the conversion with no partial word stored.

Verification
REQ-032 Reset, then write 0x800=0x2:
- BUSY=1 within 2 clocks;
- CNVST high for 32 clocks;
- 16 SCLK pulses;
- a STATUS read 200 ns after the write returns bit0=1.
REQ-033 ADC model returns 0xA5C3, COUNT=1:
- after 69 clocks, STATUS=0x0000_0102;
- read 0x000 -> 0x0000_A5C3.
REQ-034 COUNT=4, model returns 0x8000+n:
- RAM[0..3] = 0x8000..0x8003;
- STATUS[16:8]=4, DONE=1.
REQ-035 CONT=1, COUNT=1: pointer wraps after 256 samples; RAM[0] is overwritten by sample 256.
REQ-036 Assert OPB_RST mid-READ:
- CNVST/SCLK go low immediately;
- STATUS=0, no RAM write;
- a START after reset runs normally.
REQ-037 Reads of 0x900 and 0xFFC return 0; a write to 0x808 leaves STATUS unchanged.
